s86_wb_arbiter: RTL and testbench
=================================

# s86_wb_arbiter

Two-master Wishbone arbiter that shares the single S86 slave path (RAM_BIOS, read/write generator, I/O decoder, data mux, ACK generator) between the S86 processor (master 0) and a second bus master such as a DMA or debug engine (master 1). It sits between the masters and the existing slave-side fabric. It grants the bus round-robin, holds each grant for the full `cyc` tenure, and routes data and `ack` back to the owner only. An optional watchdog terminates stalled cycles.

## Interface
- `ADR_W`, 19 — word-address width; the address bus is `[ADR_W:1]`.
- `DAT_W`, 16 — data width.
- `TIMEOUT_CYCLES`, 255 — watchdog limit in clocks; 8-bit range, 1..255.

Ports:
- `wb_clk_i` — in, 1. Bus clock (CLK10MHZ domain).
- `wb_rst_n_i` — in, 1. Asynchronous, active-low reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`, `m0_tga_i` — in, 1 each. Processor request signals.
- `m0_adr_i` — in, ADR_W. Processor address.
- `m0_sel_i` — in, 2. Processor byte selects.
- `m0_dat_i` — in, DAT_W. Processor write data.
- `m0_dat_o` — out, DAT_W. Read data to processor.
- `m0_ack_o` — out, 1. Ack to processor.
- `m1_*` — same set as `m0_*` for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_tga_o`, `s_adr_o`, `s_sel_o`, `s_dat_o` — out. Muxed request to the slave fabric.
- `s_dat_i` — in, DAT_W. Read data from the slave fabric.
- `s_ack_i` — in, 1. Ack from the slave fabric.
- `gnt_o` — out, 2. One-hot current owner.
- `err_o` — out, 1. Sticky timeout flag.

## Operation
- **States:** IDLE, GNT0, GNT1. Registered state plus a `last` register holding the previous owner.
- **IDLE:**
  - Only `m0_cyc_i` high → GNT0.
  - Only `m1_cyc_i` high → GNT1.
  - Both high → grant the master that is not `last`.
  - Neither high → stay in IDLE.
- **GNTx:**
  - Hold while `mx_cyc_i` is high; multiple `stb` beats are allowed within one tenure.
  - When `mx_cyc_i` falls: if the other master's `cyc` is high, go directly to its grant; otherwise go to IDLE.
  - `last` updates to x on exit.
- **Slave mux:**
  - In GNTx, all `s_*` outputs follow master x combinationally.
  - In IDLE, `s_cyc_o`, `s_stb_o`, `s_we_o` and `s_tga_o` are 0; address, sel and data are 0.
- **Return path:**
  - `mx_ack_o = s_ack_i & gnt_o[x]`.
  - `mx_dat_o = s_dat_i` when granted, else 0.
  - The non-owner never sees `ack`.
- **Reset mid-cycle:** everything returns to reset values immediately. A slave `ack` arriving afterwards is ignored.

## Timing
- **Reset values:**
  - State IDLE, `gnt_o` = 00, `last` = 1 (master 0 wins the first contention).
  - All `s_*` outputs 0, both `m*_ack_o` 0, `err_o` 0.
- **Grant latency:** `cyc` sampled high in IDLE → grant and `s_cyc_o` asserted on the next clock edge. The master keeps `stb` asserted until `ack` (Wishbone classic).
- **Handover:**
  - Owner drops `cyc` at edge N; the other master is granted at edge N+1.
  - There is no idle gap when the other master is waiting.
  - `s_cyc_o` may stay high across the handover; `s_stb_o` follows the new owner.
- **Ack path:** same cycle, combinational, from `s_ack_i` to the owner.
- **Simultaneous events:** owner drops `cyc` while the slave asserts `ack` in the same cycle → the ack is delivered to that owner, then the grant moves.

## Configuration
- `S86_WB_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter runs while the owner has `stb` and `cyc` high and `s_ack_i` is low.
  - On reaching TIMEOUT_CYCLES, the arbiter issues a one-cycle `mx_ack_o` with `mx_dat_o` = 16'hFFFF and sets `err_o`; `s_stb_o` is forced low in that cycle.
  - The counter clears on any ack, on a grant change, and on reset.
  - `err_o` clears only on reset.
- Not defined: no counter; a stalled cycle waits indefinitely and `err_o` is tied to 0.

## Structure
- Package `s86_wb_pkg`:
  - `ADR_W`, `DAT_W` constants.
  - State enum `arb_state_t` {IDLE, GNT0, GNT1}.
  - Constant `TO_DATA` = 16'hFFFF.
- Sub-module `s86_wb_timeout`: counter plus compare, instantiated only under the macro.

## Test plan
- **Single CPU read:** m0 reads `adr` 19'h00010 with the slave acking after 3 cycles and `s_dat_i` = 16'h1234 → `gnt_o` = 01 one cycle after `cyc`; `m0_dat_o` = 16'h1234 with `m0_ack_o`; `m1_ack_o` stays 0.
- **Contention after reset:** both `cyc` raised in the same cycle → GNT0 first. m0 drops `cyc` → GNT1 on the next edge. Next contention goes to GNT0 again (round-robin).
- **Multi-beat tenure:** m1 holds `cyc` for 4 write beats to `adr` 0x100..0x103 while m0 requests → m0 is not granted until m1 drops `cyc`; all 4 `s_we_o` beats come from m1.
- **Reset mid-cycle:** `wb_rst_n_i` pulled low during GNT1 with `s_ack_i` pending → `gnt_o` = 00, all `s_*` outputs 0 immediately; a late `s_ack_i` produces no `m*_ack_o`.
- **Timeout (macro on, TIMEOUT_CYCLES = 8):** m0 strobes, slave never acks → `m0_ack_o` pulses at cycle 8 with data 16'hFFFF, `err_o` = 1 and stays set. With the macro off, no ack ever arrives.

Source files
------------

// File: rtl/s86_wb_pkg.sv
// Shared constants and types for the S86 two-master Wishbone arbiter.
package s86_wb_pkg;

  localparam int unsigned ADR_W = 19;
  localparam int unsigned DAT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } arb_state_t;

  localparam logic [DAT_W-1:0] TO_DATA = 16'hFFFF;

endpackage

// File: rtl/s86_wb_arbiter_if.sv
// Bus bundle for s86_wb_arbiter: both master request/return paths plus the shared slave path.
// The master modport is the arbiter's view; slave is the view of the masters and fabric around it.
interface s86_wb_arbiter_if;
  import s86_wb_pkg::*;

  logic             m0_cyc_i, m0_stb_i, m0_we_i, m0_tga_i;
  logic [ADR_W:1]   m0_adr_i;
  logic [1:0]       m0_sel_i;
  logic [DAT_W-1:0] m0_dat_i, m0_dat_o;
  logic             m0_ack_o;

  logic             m1_cyc_i, m1_stb_i, m1_we_i, m1_tga_i;
  logic [ADR_W:1]   m1_adr_i;
  logic [1:0]       m1_sel_i;
  logic [DAT_W-1:0] m1_dat_i, m1_dat_o;
  logic             m1_ack_o;

  logic             s_cyc_o, s_stb_o, s_we_o, s_tga_o;
  logic [ADR_W:1]   s_adr_o;
  logic [1:0]       s_sel_o;
  logic [DAT_W-1:0] s_dat_o, s_dat_i;
  logic             s_ack_i;

  logic [1:0]       gnt_o;
  logic             err_o;

  modport master (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_tga_i, m0_adr_i, m0_sel_i, m0_dat_i,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_tga_i, m1_adr_i, m1_sel_i, m1_dat_i,
    input  s_dat_i, s_ack_i,
    output m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
    output s_cyc_o, s_stb_o, s_we_o, s_tga_o, s_adr_o, s_sel_o, s_dat_o,
    output gnt_o, err_o
  );

  modport slave (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_tga_i, m0_adr_i, m0_sel_i, m0_dat_i,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_tga_i, m1_adr_i, m1_sel_i, m1_dat_i,
    output s_dat_i, s_ack_i,
    input  m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_tga_o, s_adr_o, s_sel_o, s_dat_o,
    input  gnt_o, err_o
  );

endinterface

// File: rtl/s86_wb_timeout.sv
// Stall watchdog for the arbiter: counts stalled strobe cycles and fires on the LIMIT-th one.
module s86_wb_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  input  logic clr_i,
  output logic fire_o
);

  localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Fires combinationally in the LIMIT-th stalled cycle so the forced ack lands in that cycle.
  assign fire_o = run_i & (cnt_q == LIMIT_M1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || fire_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/s86_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the S86 slave fabric.
// Optional stall watchdog enabled by defining S86_WB_ARB_TIMEOUT_EN.
module s86_wb_arbiter
  import s86_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  s86_wb_arbiter_if.master    bus
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;
  logic       to_fire;

  // last_q holds the index of the previous owner; reset to 1 so master 0 wins first contention.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_q)) state_d = GNT0;
        else if (bus.m1_cyc_i)                         state_d = GNT1;
      end
      GNT0: begin
        if (!bus.m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = bus.m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!bus.m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = bus.m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = {state_d == GNT1, state_d == GNT0};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt_o = gnt_q;

  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_tga_o = 1'b0;
    bus.s_adr_o = '0;
    bus.s_sel_o = '0;
    bus.s_dat_o = '0;
    if (gnt_q[0]) begin
      bus.s_cyc_o = bus.m0_cyc_i;
      bus.s_stb_o = bus.m0_stb_i & ~to_fire;
      bus.s_we_o  = bus.m0_we_i;
      bus.s_tga_o = bus.m0_tga_i;
      bus.s_adr_o = bus.m0_adr_i;
      bus.s_sel_o = bus.m0_sel_i;
      bus.s_dat_o = bus.m0_dat_i;
    end else if (gnt_q[1]) begin
      bus.s_cyc_o = bus.m1_cyc_i;
      bus.s_stb_o = bus.m1_stb_i & ~to_fire;
      bus.s_we_o  = bus.m1_we_i;
      bus.s_tga_o = bus.m1_tga_i;
      bus.s_adr_o = bus.m1_adr_i;
      bus.s_sel_o = bus.m1_sel_i;
      bus.s_dat_o = bus.m1_dat_i;
    end
  end

  always_comb begin
    bus.m0_ack_o = gnt_q[0] & (bus.s_ack_i | to_fire);
    bus.m1_ack_o = gnt_q[1] & (bus.s_ack_i | to_fire);
    bus.m0_dat_o = gnt_q[0] ? (to_fire ? TO_DATA : bus.s_dat_i) : '0;
    bus.m1_dat_o = gnt_q[1] ? (to_fire ? TO_DATA : bus.s_dat_i) : '0;
  end

`ifdef S86_WB_ARB_TIMEOUT_EN
  logic to_run, to_clr;
  logic err_q, err_d;

  assign to_run = ((gnt_q[0] & bus.m0_cyc_i & bus.m0_stb_i) |
                   (gnt_q[1] & bus.m1_cyc_i & bus.m1_stb_i)) & ~bus.s_ack_i;
  assign to_clr = bus.s_ack_i | (state_d != state_q);

  s86_wb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n_i),
    .run_i   (to_run),
    .clr_i   (to_clr),
    .fire_o  (to_fire)
  );

  always_comb err_d = err_q | to_fire;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  logic unused_timeout;

  assign to_fire        = 1'b0;
  assign bus.err_o      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES[7:0];
`endif

endmodule

// File: tb/tb_s86_wb_arbiter.sv
// Self-checking bench for s86_wb_arbiter: vector table, directed corner sequences, random vs model.
// Timeout expectations follow S86_WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES overridden to 8.
module tb_s86_wb_arbiter;
  import s86_wb_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: current owner (-1 none), previous owner, stalled-cycle count, sticky error.
  int   owner, last_own, stalls;
  logic err_m, fire_m;

  typedef struct packed {
    logic       c0, c1, ack;
    logic [1:0] gnt;
    logic       scyc;
    logic [1:0] acks;
  } vec_t;

  vec_t vecs [12];

  s86_wb_arbiter_if bus ();

  s86_wb_arbiter #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_tga_i = 1'b0;
    bus.m0_adr_i = '0;   bus.m0_sel_i = '0;   bus.m0_dat_i = '0;
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_tga_i = 1'b0;
    bus.m1_adr_i = '0;   bus.m1_sel_i = '0;   bus.m1_dat_i = '0;
    bus.s_ack_i  = 1'b0; bus.s_dat_i  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    owner    = -1;
    last_own = 1;
    stalls   = 0;
    err_m    = 1'b0;
  endtask

  function automatic logic [40:0] sbus_now();
    return {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_tga_o, bus.s_adr_o, bus.s_sel_o, bus.s_dat_o};
  endfunction

  function automatic logic model_stalled();
    if (owner == 0) return bus.m0_cyc_i && bus.m0_stb_i && !bus.s_ack_i;
    if (owner == 1) return bus.m1_cyc_i && bus.m1_stb_i && !bus.s_ack_i;
    return 1'b0;
  endfunction

  task automatic check_model();
    logic [40:0]      e_sbus;
    logic [1:0]       e_gnt, e_ack;
    logic [DAT_W-1:0] e_d0, e_d1, rd;
`ifdef S86_WB_ARB_TIMEOUT_EN
    fire_m = model_stalled() && (stalls == TO - 1);
`else
    fire_m = 1'b0;
`endif
    e_sbus = '0;
    if (owner == 0)
      e_sbus = {bus.m0_cyc_i, bus.m0_stb_i & ~fire_m, bus.m0_we_i, bus.m0_tga_i,
                bus.m0_adr_i, bus.m0_sel_i, bus.m0_dat_i};
    else if (owner == 1)
      e_sbus = {bus.m1_cyc_i, bus.m1_stb_i & ~fire_m, bus.m1_we_i, bus.m1_tga_i,
                bus.m1_adr_i, bus.m1_sel_i, bus.m1_dat_i};
    e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e_ack = {(owner == 1) && (bus.s_ack_i || fire_m), (owner == 0) && (bus.s_ack_i || fire_m)};
    rd    = fire_m ? 16'hFFFF : bus.s_dat_i;
    e_d0  = (owner == 0) ? rd : '0;
    e_d1  = (owner == 1) ? rd : '0;
    check("rnd_gnt",  64'(bus.gnt_o), 64'(e_gnt));
    check("rnd_sbus", 64'(sbus_now()), 64'(e_sbus));
    check("rnd_ack",  64'({bus.m1_ack_o, bus.m0_ack_o}), 64'(e_ack));
    check("rnd_dat",  64'({bus.m1_dat_o, bus.m0_dat_o}), 64'({e_d1, e_d0}));
    check("rnd_err",  64'(bus.err_o), 64'(err_m));
  endtask

  task automatic model_advance();
    int   nxt;
    logic stl;
    nxt = owner;
    stl = model_stalled();
    if (owner < 0) begin
      if (bus.m0_cyc_i && bus.m1_cyc_i) nxt = (last_own == 1) ? 0 : 1;
      else if (bus.m0_cyc_i)            nxt = 0;
      else if (bus.m1_cyc_i)            nxt = 1;
    end else if (owner == 0 && !bus.m0_cyc_i) begin
      last_own = 0;
      nxt      = bus.m1_cyc_i ? 1 : -1;
    end else if (owner == 1 && !bus.m1_cyc_i) begin
      last_own = 1;
      nxt      = bus.m0_cyc_i ? 0 : -1;
    end
    if (bus.s_ack_i || fire_m || nxt != owner) stalls = 0;
    else if (stl)                              stalls++;
    err_m = err_m | fire_m;
    owner = nxt;
  endtask

  task automatic rand_inputs();
    if (bus.m0_cyc_i) bus.m0_cyc_i = ($urandom_range(7) != 0);
    else              bus.m0_cyc_i = ($urandom_range(2) == 0);
    if (bus.m1_cyc_i) bus.m1_cyc_i = ($urandom_range(7) != 0);
    else              bus.m1_cyc_i = ($urandom_range(2) == 0);
    bus.m0_stb_i = 1'($urandom);  bus.m1_stb_i = 1'($urandom);
    bus.m0_we_i  = 1'($urandom);  bus.m1_we_i  = 1'($urandom);
    bus.m0_tga_i = 1'($urandom);  bus.m1_tga_i = 1'($urandom);
    bus.m0_adr_i = 19'($urandom); bus.m1_adr_i = 19'($urandom);
    bus.m0_sel_i = 2'($urandom);  bus.m1_sel_i = 2'($urandom);
    bus.m0_dat_i = 16'($urandom); bus.m1_dat_i = 16'($urandom);
    bus.s_dat_i  = 16'($urandom);
    bus.s_ack_i  = ($urandom_range(2) == 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00};

    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("rst_gnt",  64'(bus.gnt_o), 64'd0);
    check("rst_sbus", 64'(sbus_now()), 64'd0);
    check("rst_ack",  64'({bus.m1_ack_o, bus.m0_ack_o}), 64'd0);
    check("rst_err",  64'(bus.err_o), 64'd0);
    do_reset();

    // Contention and round-robin table
    for (int i = 0; i < 12; i++) begin
      bus.m0_cyc_i = vecs[i].c0; bus.m0_stb_i = vecs[i].c0;
      bus.m1_cyc_i = vecs[i].c1; bus.m1_stb_i = vecs[i].c1;
      bus.s_ack_i  = vecs[i].ack; bus.s_dat_i = 16'h5A5A;
      #1;
      check($sformatf("vec%0d_gnt", i),  64'(bus.gnt_o), 64'(vecs[i].gnt));
      check($sformatf("vec%0d_scyc", i), 64'(bus.s_cyc_o), 64'(vecs[i].scyc));
      check($sformatf("vec%0d_acks", i), 64'({bus.m1_ack_o, bus.m0_ack_o}), 64'(vecs[i].acks));
      tick();
    end
    clear_inputs();
    tick();

    // Single CPU read, slave acks in the third granted cycle
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 19'h00010; bus.m0_sel_i = 2'b11;
    #1 check("rd_gnt_pre", 64'(bus.gnt_o), 64'd0);
    tick();
    check("rd_gnt",  64'(bus.gnt_o), 64'd1);
    check("rd_scyc", 64'(bus.s_cyc_o), 64'd1);
    check("rd_sadr", 64'(bus.s_adr_o), 64'h10);
    for (int i = 0; i < 2; i++) begin
      #1 check("rd_wait_ack", 64'(bus.m0_ack_o), 64'd0);
      tick();
    end
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h1234;
    #1;
    check("rd_ack",   64'(bus.m0_ack_o), 64'd1);
    check("rd_dat",   64'(bus.m0_dat_o), 64'h1234);
    check("rd_m1ack", 64'(bus.m1_ack_o), 64'd0);
    check("rd_m1dat", 64'(bus.m1_dat_o), 64'd0);
    tick();
    clear_inputs();
    tick();

    // Multi-beat m1 tenure while m0 waits
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_adr_i = 19'h100;
    #1 check("mb_gnt_pre", 64'(bus.gnt_o), 64'd0);
    tick();
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.m1_adr_i = 19'(32'h100 + i); bus.m1_dat_i = 16'(16'hA0 + i); bus.s_ack_i = 1'b1;
      #1;
      check($sformatf("mb%0d_gnt", i),   64'(bus.gnt_o), 64'd2);
      check($sformatf("mb%0d_we", i),    64'(bus.s_we_o), 64'd1);
      check($sformatf("mb%0d_adr", i),   64'(bus.s_adr_o), 64'(32'h100 + i));
      check($sformatf("mb%0d_acks", i),  64'({bus.m1_ack_o, bus.m0_ack_o}), 64'd2);
      tick();
    end
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.s_ack_i = 1'b0;
    #1 check("mb_drop_gnt", 64'(bus.gnt_o), 64'd2);
    tick();
    bus.s_ack_i = 1'b1;
    #1;
    check("mb_hand_gnt", 64'(bus.gnt_o), 64'd1);
    check("mb_hand_we",  64'(bus.s_we_o), 64'd0);
    check("mb_hand_ack", 64'({bus.m1_ack_o, bus.m0_ack_o}), 64'd1);
    tick();
    clear_inputs();
    tick();

    // Stalled m0 strobe: watchdog or indefinite wait
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    tick();
`ifdef S86_WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      #1;
      check($sformatf("to_ack_c%0d", k), 64'(bus.m0_ack_o), 64'(k == TO));
      check($sformatf("to_err_c%0d", k), 64'(bus.err_o), 64'd0);
      if (k == TO) begin
        check("to_dat",  64'(bus.m0_dat_o), 64'hFFFF);
        check("to_sstb", 64'(bus.s_stb_o), 64'd0);
      end
      tick();
    end
    clear_inputs();
    check("to_err_set", 64'(bus.err_o), 64'd1);
    repeat (3) tick();
    check("to_err_sticky", 64'(bus.err_o), 64'd1);
`else
    for (int k = 1; k <= 20; k++) begin
      #1;
      check($sformatf("noto_ack_c%0d", k), 64'(bus.m0_ack_o), 64'd0);
      check($sformatf("noto_err_c%0d", k), 64'(bus.err_o), 64'd0);
      tick();
    end
    clear_inputs();
    tick();
`endif

    // Reset in the middle of an m1 tenure with the slave ack pending
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 19'h7ABCD; bus.m1_we_i = 1'b1;
    tick();
    #1 check("mr_gnt_pre", 64'(bus.gnt_o), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check("mr_gnt",  64'(bus.gnt_o), 64'd0);
    check("mr_sbus", 64'(sbus_now()), 64'd0);
    check("mr_err",  64'(bus.err_o), 64'd0);
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'hBEEF;
    #1;
    check("mr_late_ack", 64'({bus.m1_ack_o, bus.m0_ack_o}), 64'd0);
    check("mr_late_dat", 64'({bus.m1_dat_o, bus.m0_dat_o}), 64'd0);
    @(posedge clk);
    #1 check("mr_gnt_hold", 64'(bus.gnt_o), 64'd0);
    @(negedge clk);

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      #1 check_model();
      @(posedge clk);
      model_advance();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
